aes_round_key_gen: RTL and testbench

AES-128 round-key generator. It sits directly upstream of the AES decryption core and feeds its key request port. On a load strobe it expands a 128-bit cipher key into round keys 0..10, one round per cycle, and stores them. It then answers `key_req`/`key_sel` lookups with the selected round key and a valid flag. Any round key can be requested in any order, which matches the descending 10→0 order the decryption core uses.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_sbox_word.sv | 19 +
 rtl/aes_round_key_gen.sv | 202 ++++++++++++++++++++
 tb/tb_aes_round_key_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the round-key generator slice.
// - aes_matrix_t   : 4x4 byte matrix; byte k(n) sits at [n%4][n/4], each column is one word.
// - keygen_state_t : key-expansion FSM states.
// - AES_RCON       : round constants for rounds 1..10 (index = round - 1).
// - AES_SBOX       : forward S-box table.
package aes_pkg;

  localparam int unsigned AES_NO_ROWS   = 4;
  localparam int unsigned AES_NO_COLS   = 4;
  localparam int unsigned AES_NO_ROUNDS = 10;

  typedef logic [7:0] aes_matrix_t [AES_NO_ROWS][AES_NO_COLS];

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExpand = 2'd1,
    StReady  = 2'd2
  } keygen_state_t;

  localparam logic [7:0] AES_RCON [AES_NO_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word.
// Ports:
//   word_i : input word, byte 0 (row 0) in bits [31:24]
//   word_o : substituted word, same byte order
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < 4; i++) begin
      word_o[8*i +: 8] = AES_SBOX[word_i[8*i +: 8]];
    end
  end

endmodule

// File: rtl/aes_round_key_gen.sv
// AES-128 round-key generator. A load strobe captures the cipher key as rk[0] and expands
// rk[1]..rk[10] one round per cycle into a key store; afterwards any round key can be
// looked up with key_req_i/key_sel_i and appears one cycle later with key_vld_o.
//
// Ports:
//   aes_clk      : clock, rising edge
//   reset        : synchronous active-high reset
//   cipher_key_i : 128-bit cipher key as a 4x4 byte matrix (column = word)
//   key_load_i   : capture cipher_key_i and start expansion (IDLE or READY)
//   key_clear_i  : zeroize request, only honoured with AES_KEY_ZEROIZE_EN
//   key_busy_o   : expansion in progress
//   key_rdy_o    : all 11 round keys stored
//   key_req_i    : round-key lookup request
//   key_sel_i    : requested round 0..10
//   key_vld_o    : round_key_o holds rk[sel] of the previous-cycle request
//   round_key_o  : selected round key (held while no request is active)
//   key_err_o    : one-cycle pulse for a request with key_sel_i > 10
//
// Build option: define AES_KEY_ZEROIZE_EN to make key_clear_i wipe the key store, the output
// key and all flags (highest priority). Without it key_clear_i is ignored.
module aes_round_key_gen
  import aes_pkg::*;
#(
  parameter int unsigned NO_ROWS   = AES_NO_ROWS,
  parameter int unsigned NO_COLS   = AES_NO_COLS,
  parameter int unsigned NO_ROUNDS = AES_NO_ROUNDS
) (
  input  logic       aes_clk,
  input  logic       reset,
  input  logic [7:0] cipher_key_i [NO_ROWS][NO_COLS],
  input  logic       key_load_i,
  input  logic       key_clear_i,
  output logic       key_busy_o,
  output logic       key_rdy_o,
  input  logic       key_req_i,
  input  logic [3:0] key_sel_i,
  output logic       key_vld_o,
  output logic [7:0] round_key_o [NO_ROWS][NO_COLS],
  output logic       key_err_o
);

  localparam logic [3:0] LastRound = 4'(NO_ROUNDS);

  keygen_state_t state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [7:0]    rk_q [NO_ROUNDS+1][NO_ROWS][NO_COLS];
  logic [7:0]    rk_d [NO_ROUNDS+1][NO_ROWS][NO_COLS];
  logic [7:0]    round_key_q [NO_ROWS][NO_COLS];
  logic [7:0]    round_key_d [NO_ROWS][NO_COLS];
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic          busy_q, rdy_q;

  // Expansion datapath: rk[round] from rk[round-1]
  logic [3:0]  prev_idx;
  aes_matrix_t prev_key;
  aes_matrix_t next_key;
  logic [31:0] rot_word;
  logic [31:0] sub_word;
  logic [7:0]  rcon;

  // round_q is only 0 outside EXPAND; clamp so the read index stays in range
  assign prev_idx = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
  assign prev_key = rk_q[prev_idx];
  assign rcon     = (prev_idx < LastRound) ? AES_RCON[prev_idx] : 8'h00;

  // RotWord on column 3: row 0 takes row 1, row 3 wraps to row 0
  assign rot_word = {prev_key[1][3], prev_key[2][3], prev_key[3][3], prev_key[0][3]};

  aes_sbox_word u_sbox_word (
    .word_i (rot_word),
    .word_o (sub_word)
  );

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        next_key[r][c] = 8'h00;
      end
    end
    for (int r = 0; r < 4; r++) begin
      next_key[r][0] = prev_key[r][0] ^ sub_word[8*(3-r) +: 8];
    end
    next_key[0][0] = next_key[0][0] ^ rcon;
    // Each later word chains on the freshly computed word to its left
    for (int c = 1; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        next_key[r][c] = prev_key[r][c] ^ next_key[r][c-1];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    rk_d        = rk_q;
    round_key_d = round_key_q;
    vld_d       = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (key_load_i) begin
          rk_d[0] = cipher_key_i;
          round_d = 4'd1;
          state_d = StExpand;
        end
      end
      StExpand: begin
        rk_d[round_q] = next_key;
        if (round_q >= LastRound) begin
          state_d = StReady;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      StReady: begin
        // A reload wins over a simultaneous request
        if (key_load_i) begin
          rk_d[0] = cipher_key_i;
          round_d = 4'd1;
          state_d = StExpand;
        end else if (key_req_i) begin
          if (key_sel_i <= LastRound) begin
            vld_d       = 1'b1;
            round_key_d = rk_q[key_sel_i];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef AES_KEY_ZEROIZE_EN
    if (key_clear_i) begin
      state_d = StIdle;
      round_d = 4'd0;
      vld_d   = 1'b0;
      err_d   = 1'b0;
      for (int k = 0; k <= int'(NO_ROUNDS); k++) begin
        for (int r = 0; r < int'(NO_ROWS); r++) begin
          for (int c = 0; c < int'(NO_COLS); c++) begin
            rk_d[k][r][c] = 8'h00;
          end
        end
      end
      for (int r = 0; r < int'(NO_ROWS); r++) begin
        for (int c = 0; c < int'(NO_COLS); c++) begin
          round_key_d[r][c] = 8'h00;
        end
      end
    end
`endif
  end

`ifndef AES_KEY_ZEROIZE_EN
  logic unused_key_clear;
  assign unused_key_clear = key_clear_i;
`endif

  always_ff @(posedge aes_clk) begin
    if (reset) begin
      state_q <= StIdle;
      round_q <= 4'd0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      for (int k = 0; k <= int'(NO_ROUNDS); k++) begin
        for (int r = 0; r < int'(NO_ROWS); r++) begin
          for (int c = 0; c < int'(NO_COLS); c++) begin
            rk_q[k][r][c] <= 8'h00;
          end
        end
      end
      for (int r = 0; r < int'(NO_ROWS); r++) begin
        for (int c = 0; c < int'(NO_COLS); c++) begin
          round_key_q[r][c] <= 8'h00;
        end
      end
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      rk_q        <= rk_d;
      round_key_q <= round_key_d;
      vld_q       <= vld_d;
      err_q       <= err_d;
      busy_q      <= (state_d == StExpand);
      rdy_q       <= (state_d == StReady);
    end
  end

  assign key_busy_o  = busy_q;
  assign key_rdy_o   = rdy_q;
  assign key_vld_o   = vld_q;
  assign key_err_o   = err_q;
  assign round_key_o = round_key_q;

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Directed bench for aes_round_key_gen with a scoreboard: each request pushes its expected
// response; a negedge monitor pops and compares whenever key_vld_o or key_err_o is high.
module tb_aes_round_key_gen;

  logic       aes_clk = 1'b0;
  logic       reset;
  logic [7:0] cipher_key [4][4];
  logic       key_load;
  logic       key_clear;
  logic       key_busy;
  logic       key_rdy;
  logic       key_req;
  logic [3:0] key_sel;
  logic       key_vld;
  logic [7:0] round_key [4][4];
  logic       key_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_err;
    logic [127:0] key;
  } exp_t;
  exp_t exp_q [$];

  // FIPS-197 A.1 schedule for key 2b7e1516 28aed2a6 abf71588 09cf4f3c
  logic [127:0] rk_a [11] = '{
    128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
    128'ha0fafe17_88542cb1_23a33939_2a6c7605,
    128'hf2c295f2_7a96b943_5935807a_7359f67f,
    128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
    128'hef44a541_a8525b7f_b671253b_db0bad00,
    128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
    128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
    128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
    128'head27321_b58dbad2_312bf560_7f8d292f,
    128'hac7766f3_19fadc21_28d12941_575c006e,
    128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
  };
  logic [127:0] zero_rk10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  always #5 aes_clk = ~aes_clk;

  aes_round_key_gen dut (
    .aes_clk      (aes_clk),
    .reset        (reset),
    .cipher_key_i (cipher_key),
    .key_load_i   (key_load),
    .key_clear_i  (key_clear),
    .key_busy_o   (key_busy),
    .key_rdy_o    (key_rdy),
    .key_req_i    (key_req),
    .key_sel_i    (key_sel),
    .key_vld_o    (key_vld),
    .round_key_o  (round_key),
    .key_err_o    (key_err)
  );

  function automatic logic [127:0] rk_vec();
    logic [127:0] v;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        v[127-8*(4*c+r) -: 8] = round_key[r][c];
      end
    end
    return v;
  endfunction

  task automatic set_key(input logic [127:0] k);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        cipher_key[r][c] = k[127-8*(4*c+r) -: 8];
      end
    end
  endtask

  task automatic tick();
    @(posedge aes_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_err, input logic [127:0] key);
    exp_t e;
    e.is_err = is_err;
    e.key    = key;
    exp_q.push_back(e);
  endtask

  task automatic load_key(input logic [127:0] k);
    set_key(k);
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // Single request: response one edge later, gone the edge after the request drops
  task automatic request(input logic [3:0] sel, input bit is_err, input logic [127:0] key);
    key_req = 1'b1;
    key_sel = sel;
    push(is_err, key);
    tick();
    chk("req_vld", 128'(key_vld), 128'(!is_err));
    chk("req_err", 128'(key_err), 128'(is_err));
    key_req = 1'b0;
    tick();
    chk("drop_vld", 128'(key_vld), 128'(0));
    chk("drop_err", 128'(key_err), 128'(0));
  endtask

  // Scoreboard monitor
  always @(negedge aes_clk) begin
    exp_t e;
    if (key_vld || key_err) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: vld=%0b err=%0b key=%h, wanted no output",
                 key_vld, key_err, rk_vec());
      end else begin
        e = exp_q.pop_front();
        if (e.is_err ? (key_err !== 1'b1 || key_vld !== 1'b0)
                     : (key_vld !== 1'b1 || key_err !== 1'b0 || rk_vec() !== e.key)) begin
          errors++;
          $display("FAIL scoreboard: vld=%0b err=%0b key=%h, wanted err=%0b key=%h",
                   key_vld, key_err, rk_vec(), e.is_err, e.key);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    key_load  = 1'b0;
    key_clear = 1'b0;
    key_req   = 1'b0;
    key_sel   = 4'd0;
    set_key(128'h0);
    tick();
    tick();
    chk("rst_busy", 128'(key_busy), 128'(0));
    chk("rst_rdy", 128'(key_rdy), 128'(0));
    chk("rst_vld", 128'(key_vld), 128'(0));
    chk("rst_err", 128'(key_err), 128'(0));
    chk("rst_key", rk_vec(), 128'h0);
    reset = 1'b0;
    tick();

    // Expansion timing, with a request during EXPAND that must be ignored
    load_key(rk_a[0]);
    for (int i = 0; i <= 10; i++) begin
      chk($sformatf("exp_busy_%0d", i), 128'(key_busy), 128'(i < 10));
      chk($sformatf("exp_rdy_%0d", i), 128'(key_rdy), 128'(i == 10));
      chk($sformatf("exp_vld_%0d", i), 128'(key_vld), 128'(0));
      key_req = (i == 2);
      key_sel = 4'd1;
      if (i < 10) tick();
    end

    // Single lookups and out-of-range select
    request(4'd1, 1'b0, rk_a[1]);
    request(4'd10, 1'b0, rk_a[10]);
    request(4'd0, 1'b0, rk_a[0]);
    request(4'd11, 1'b1, 128'h0);

    // Descending sweep with key_req_i held
    key_req = 1'b1;
    for (int s = 10; s >= 0; s--) begin
      key_sel = 4'(s);
      push(1'b0, rk_a[s]);
      tick();
      chk($sformatf("sweep_vld_%0d", s), 128'(key_vld), 128'(1));
    end
    key_req = 1'b0;
    tick();
    chk("hold_vld", 128'(key_vld), 128'(0));
    chk("hold_key", rk_vec(), rk_a[0]);

    // Reload with an all-zero key; load beats the simultaneous request
    set_key(128'h0);
    key_load = 1'b1;
    key_req  = 1'b1;
    key_sel  = 4'd5;
    tick();
    key_load = 1'b0;
    key_req  = 1'b0;
    chk("reload_rdy", 128'(key_rdy), 128'(0));
    chk("reload_busy", 128'(key_busy), 128'(1));
    chk("reload_vld", 128'(key_vld), 128'(0));
    repeat (10) tick();
    chk("reload_done", 128'(key_rdy), 128'(1));
    request(4'd10, 1'b0, zero_rk10);

    // Clear together with a request
    key_clear = 1'b1;
    key_req   = 1'b1;
    key_sel   = 4'd10;
`ifdef AES_KEY_ZEROIZE_EN
    tick();
    chk("clr_key", rk_vec(), 128'h0);
    chk("clr_rdy", 128'(key_rdy), 128'(0));
    chk("clr_vld", 128'(key_vld), 128'(0));
`else
    push(1'b0, zero_rk10);
    tick();
    chk("clr_ignored_rdy", 128'(key_rdy), 128'(1));
    chk("clr_ignored_vld", 128'(key_vld), 128'(1));
`endif
    key_clear = 1'b0;
    key_req   = 1'b0;
    tick();

    // Reset in the middle of expansion (round 5 in flight)
    load_key(rk_a[0]);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", 128'(key_busy), 128'(0));
    chk("mid_rst_rdy", 128'(key_rdy), 128'(0));
    chk("mid_rst_vld", 128'(key_vld), 128'(0));
    chk("mid_rst_err", 128'(key_err), 128'(0));
    chk("mid_rst_key", rk_vec(), 128'h0);
    reset = 1'b0;

    // Requests in IDLE are ignored
    key_req = 1'b1;
    key_sel = 4'd0;
    tick();
    chk("idle_vld", 128'(key_vld), 128'(0));
    chk("idle_err", 128'(key_err), 128'(0));
    key_req = 1'b0;

    load_key(rk_a[0]);
    repeat (10) tick();
    request(4'd5, 1'b0, rk_a[5]);
    request(4'd9, 1'b0, rk_a[9]);

    tick();
    tick();
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
